fifo_bram: RTL

//   Parametrised synchronous FIFO. Storage is a dual-port RAM with one write port and an asynchronous read port.

---
 rtl/fifo_bram_pkg.sv | 21 ++
 rtl/fifo_bram_ram.sv | 27 ++
 rtl/fifo_bram.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_bram_pkg.sv
// Shared types for the fifo_bram slice: how the fill level moves on each clock edge.
package fifo_bram_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } level_op_t;

    // A simultaneous push and pop leaves the level where it is.
    function automatic level_op_t level_op(input logic push, input logic pop);
        level_op_t op;
        op = LVL_HOLD;
        if (push && !pop)
            op = LVL_INC;
        else if (pop && !push)
            op = LVL_DEC;
        return op;
    endfunction

endpackage

// File: rtl/fifo_bram_ram.sv
// Dual-port RAM: one synchronous write port, two asynchronous read ports.
module bram_dp #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [WIDTH-1:0]      di,
    input  logic [ADDR_WIDTH-1:0] dpra,
    output logic [WIDTH-1:0]      spo,
    output logic [WIDTH-1:0]      dpo
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] ram [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            ram[a] <= di;
    end

    assign spo = ram[a];
    assign dpo = ram[dpra];

endmodule

// File: rtl/fifo_bram.sv
// First-word-fall-through synchronous FIFO with fill level, almost flags and sticky error flags.
module fifo_bram
    import fifo_bram_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int AFULL_LEVEL  = 2040,
    parameter int AEMPTY_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [WIDTH-1:0] spo_unused;

    assign full  = (level_reg == DEPTH_L);
    assign empty = (level_reg == '0);

    // Flush discards any transfer offered in the same cycle, including the RAM write.
    assign push = in_valid  & ~full  & ~flush;
    assign pop  = out_ready & ~empty & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
            case (level_op(push, pop))
                LVL_INC: level_reg <= level_reg + LW'(1);
                LVL_DEC: level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (in_valid && full)
                overflow_reg <= 1'b1;
            if (out_ready && empty)
                underflow_reg <= 1'b1;
        end
    end

    bram_dp #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .a    (wr_ptr_reg),
        .di   (in_data),
        .dpra (rd_ptr_reg),
        .spo  (spo_unused),
        .dpo  (out_data)
    );

    assign in_ready     = ~full;
    assign out_valid    = ~empty;
    assign level        = level_reg;
    assign almost_full  = (level_reg >= AFULL_L);
    assign almost_empty = (level_reg <= AEMPTY_L);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
